out_byte_writer: RTL and testbench

Upstream feeder for the bit-addressable output latch selector. It accepts a byte or single-bit write request from the instruction/IO decode stage. It serialises the request into one-bit-per-cycle latch writes on the data/write/addr bus that the output latch selector consumes. It honours writeDisable back-pressure and a per-bit write mask, and reports busy/done to the requester.

---
 rtl/out_byte_writer_pkg.sv | 12 +
 rtl/out_byte_writer.sv | 80 ++++++++
 tb/tb_out_byte_writer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/out_byte_writer_pkg.sv
// Shared definitions for the output-latch write path: default latch geometry
// and the serialiser state encoding.
package out_byte_writer_pkg;
  localparam int OBW_WIDTH  = 8;
  localparam int OBW_ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } obw_state_e;
endpackage

// File: rtl/out_byte_writer.sv
// Serialises a byte or single-bit request into one-bit-per-cycle latch writes,
// LSB first, honouring downstream writeDisable and a per-bit write mask.
module out_byte_writer
  import out_byte_writer_pkg::*;
#(
  parameter int WIDTH  = OBW_WIDTH,
  parameter int ADDR_W = OBW_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_mode,
  input  logic [WIDTH-1:0]  byte_data,
  input  logic [WIDTH-1:0]  mask,
  input  logic [ADDR_W-1:0] bit_addr,
  input  logic              bit_data,
  input  logic              writeDisable,
  output logic              data,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done
);

  localparam logic [WIDTH-1:0]  ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIDTH-1);

  obw_state_e        r_state, w_next;
  logic [ADDR_W-1:0] r_idx, r_last;
  logic [WIDTH-1:0]  r_shreg, r_mreg;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_WRITE;
      ST_WRITE: if (!writeDisable && (r_idx == r_last)) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_last  <= '0;
      r_shreg <= '0;
      r_mreg  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (start) begin
          if (byte_mode) begin
            r_shreg <= byte_data;
            r_mreg  <= mask;
            r_idx   <= '0;
            r_last  <= LAST_IDX;
          end else begin
            // Single-bit request reuses the byte path as a one-entry window.
            r_shreg           <= '0;
            r_shreg[bit_addr] <= bit_data;
            r_mreg            <= ONE_HOT0 << bit_addr;
            r_idx             <= bit_addr;
            r_last            <= bit_addr;
          end
        end
        ST_WRITE: if (!writeDisable && (r_idx != r_last)) r_idx <= r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Stall is folded in combinationally so the selector never sees a stale strobe.
  assign addr  = r_idx;
  assign data  = r_shreg[r_idx];
  assign write = (r_state == ST_WRITE) & r_mreg[r_idx] & ~writeDisable;
  assign busy  = (r_state != ST_IDLE);
  assign done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_out_byte_writer.sv
// Directed bench: expected latch writes queued at stimulus time, popped by a
// monitor on each observed write; done timing and latch contents checked.
module tb_out_byte_writer;
  typedef struct packed { logic [2:0] a; logic d; } wr_t;

  logic       clk = 1'b0;
  logic       rst, start, byte_mode, bit_data, writeDisable;
  logic [7:0] byte_data, mask;
  logic [2:0] bit_addr;
  logic       data, write, busy, done;
  logic [2:0] addr;

  int   checks = 0, fails = 0, done_cnt = 0;
  logic [7:0] lat = '0;
  wr_t  exp_q[$];

  out_byte_writer #(.WIDTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_mode(byte_mode),
    .byte_data(byte_data), .mask(mask), .bit_addr(bit_addr), .bit_data(bit_data),
    .writeDisable(writeDisable), .data(data), .write(write), .addr(addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Latch model + scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    if (write) begin
      if (exp_q.size() == 0) chk("unexpected_write", {29'd0, addr}, 32'hFFFF);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {29'd0, addr}, {29'd0, e.a});
        chk("wr_data", {31'd0, data}, {31'd0, e.d});
      end
      lat[addr] = data;
    end
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) exp_q.push_back('{a: 3'(i), d: d[i]});
  endtask

  task automatic go_byte(input logic [7:0] d, input logic [7:0] m);
    byte_mode = 1'b1; byte_data = d; mask = m; start = 1'b1;
    step(); start = 1'b0;
  endtask

  // Continue from cycle cyc until done is seen; bounded.
  task automatic run_to_done(input int cyc, input int exp_cyc, input string tag);
    while (!done && cyc < 60) begin step(); cyc++; end
    chk(tag, cyc, exp_cyc);
    step();
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_q_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; byte_mode = 1'b0; byte_data = '0; mask = '0;
    bit_addr = '0; bit_data = 1'b0; writeDisable = 1'b0;
    step(); step();
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_addr",  {29'd0, addr},  32'd0);
    chk("rst_data",  {31'd0, data},  32'd0);
    rst = 1'b1; step();

    // Byte A5, no stall
    lat = '0; d0 = done_cnt;
    push_byte(8'hA5, 8'hFF);
    go_byte(8'hA5, 8'hFF);
    chk("a5_busy_c1", {31'd0, busy}, 32'd1);
    chk("a5_write_c1", {31'd0, write}, 32'd1);
    run_to_done(1, 9, "a5_done_cycle");
    chk("a5_latch", {24'd0, lat}, 32'hA5);
    chk("a5_done_cnt", done_cnt - d0, 32'd1);

    // Masked byte
    lat = '0;
    push_byte(8'hFF, 8'h0F);
    go_byte(8'hFF, 8'h0F);
    run_to_done(1, 9, "mask_done_cycle");
    chk("mask_latch", {24'd0, lat}, 32'h0F);

    // Stall during cycles 3..5
    lat = '0; d0 = done_cnt;
    push_byte(8'h3C, 8'hFF);
    go_byte(8'h3C, 8'hFF);
    step(); step();
    writeDisable = 1'b1; #1;
    for (int c = 3; c <= 5; c++) begin
      chk("stall_addr", {29'd0, addr}, 32'd2);
      chk("stall_write", {31'd0, write}, 32'd0);
      if (c < 5) step();
    end
    step(); writeDisable = 1'b0;
    run_to_done(6, 12, "stall_done_cycle");
    chk("stall_latch", {24'd0, lat}, 32'h3C);
    chk("stall_done_cnt", done_cnt - d0, 32'd1);

    // Single bit
    lat = '0;
    exp_q.push_back('{a: 3'd6, d: 1'b1});
    byte_mode = 1'b0; bit_addr = 3'd6; bit_data = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    chk("bit_write_c1", {31'd0, write}, 32'd1);
    chk("bit_addr_c1", {29'd0, addr}, 32'd6);
    run_to_done(1, 2, "bit_done_cycle");
    chk("bit_latch", {24'd0, lat}, 32'h40);

    // Start while busy is ignored
    lat = '0; d0 = done_cnt;
    push_byte(8'hFF, 8'hFF);
    go_byte(8'hFF, 8'hFF);
    step(); step(); step();
    byte_data = 8'h00; start = 1'b1;
    step(); start = 1'b0;
    run_to_done(5, 9, "busy_done_cycle");
    step();
    chk("busy_idle_c11", {31'd0, busy}, 32'd0);
    chk("busy_latch", {24'd0, lat}, 32'hFF);
    chk("busy_done_cnt", done_cnt - d0, 32'd1);

    // mask=0: silent run; writeDisable in DONE must not delay return
    d0 = done_cnt;
    go_byte(8'hFF, 8'h00);
    for (int c = 1; c < 8; c++) step();
    writeDisable = 1'b0; step(); writeDisable = 1'b1; #1;
    chk("mask0_done_c9", {31'd0, done}, 32'd1);
    step(); writeDisable = 1'b0;
    chk("mask0_idle_c10", {31'd0, busy}, 32'd0);
    chk("mask0_latch", {24'd0, lat}, 32'hFF);

    // Reset mid-byte: bits 0..2 written, then abandoned
    lat = '0; d0 = done_cnt;
    push_byte(8'hFF, 8'h07);
    go_byte(8'hFF, 8'hFF);
    step(); step();
    rst = 1'b0;
    step();
    chk("midrst_write", {31'd0, write}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_addr", {29'd0, addr}, 32'd0);
    step(); rst = 1'b1;
    for (int c = 0; c < 12; c++) step();
    chk("midrst_latch", {24'd0, lat}, 32'h07);
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    chk("midrst_q_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
